// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-memory MMIO splitter: register offsets, STATUS layout, TX FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dmem_mmio_pkg;

   // Register offsets inside the 16-word MMIO window
   localparam logic [3:0] REG_TXDATA = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h1;
   localparam logic [3:0] REG_CTRL   = 4'h2;

   // STATUS word bit positions
   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_COUNT_LSB = 8;

   // UART transmitter frame states
   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } txState_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count; storage is not reset, only pointers/count.
// Latency: pushed entry visible on popData the cycle after the push edge (show-ahead read).
// Backpressure: none internally; caller must only push when not full, or when full with a pop on the same edge.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;

   // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged
   always_ff @(posedge clock) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + AW'(1);
         if (pop)  rdPtr <= rdPtr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; written without reset since stale entries are never read
   always_ff @(posedge clock) begin
      if (push) mem[wrPtr] <= pushData;
   end

   assign popData = mem[rdPtr];
   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);

endmodule

// File: rtl/dmem_mmio_uart.sv
// Data-bus splitter: 16-word MMIO window at top of 12-bit space holds a FIFO-buffered UART TX; rest goes to RAM.
// Latency: loads return one cycle after address (RAM-matched); TX frame starts one edge after first push into empty FIFO.
// Backpressure: none to the CPU; TXDATA stores into a full FIFO are dropped and flag sticky overflow.
// Build option: define UART_PARITY_EN to insert an even-parity bit between data and stop (8E1 instead of 8N1).
module dmem_mmio_uart #(
   parameter logic [11:0] MMIO_BASE    = 12'hFF0,
   parameter int          FIFO_DEPTH   = 16,
   parameter int          CLKS_PER_BIT = 868
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_wren,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        ram_wren,
   output logic [11:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        uart_tx
);
   import dmem_mmio_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] LAST_TICK = BW'(CLKS_PER_BIT - 1);

   logic          hit;
   logic [3:0]    offset;
   logic          txPush;
   logic          ovfClear;
   logic          fifoPush;
   logic          fifoPop;
   logic          ovfSet;
   logic [7:0]    fifoData;
   logic          fifoFull;
   logic          fifoEmpty;
   logic [CW-1:0] fifoCount;
   logic          overflow;
   logic [31:0]   statusWord;
   logic [31:0]   mmioRead;
   logic          selQ;
   logic [31:0]   mmioQ;
   txState_t      state;
   logic [BW-1:0] bitCnt;
   logic [2:0]    bitIdx;
   logic [7:0]    shiftReg;
   logic          lastTick;
   logic          unusedAddrBits;

   // Only the low 12 address bits are decoded
   assign unusedAddrBits = ^cpu_addr[31:12];

   assign hit       = (cpu_addr[11:4] == MMIO_BASE[11:4]);
   assign offset    = cpu_addr[3:0];
   assign ram_wren  = cpu_wren & ~hit;
   assign ram_addr  = cpu_addr[11:0];
   assign ram_wdata = cpu_wdata;

   assign txPush   = cpu_wren & hit & (offset == REG_TXDATA);
   assign ovfClear = cpu_wren & hit & (offset == REG_CTRL) & cpu_wdata[0];
   assign lastTick = (bitCnt == LAST_TICK);

   // The transmitter takes the next byte whenever it is idle or finishing a stop bit
   assign fifoPop  = ~fifoEmpty & ((state == TX_IDLE) | ((state == TX_STOP) & lastTick));
   assign fifoPush = txPush & (~fifoFull | fifoPop);
   assign ovfSet   = txPush & fifoFull & ~fifoPop;

   sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) txFifo (
      .clock    (clock),
      .reset    (reset),
      .push     (fifoPush),
      .pushData (cpu_wdata[7:0]),
      .pop      (fifoPop),
      .popData  (fifoData),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
   );

   // STATUS assembly and MMIO read mux (write-only and reserved offsets read as zero)
   always_comb begin
      statusWord                       = '0;
      statusWord[ST_COUNT_LSB +: 8]    = 8'(fifoCount);
      statusWord[ST_OVERFLOW]          = overflow;
      statusWord[ST_BUSY]              = (state != TX_IDLE);
      statusWord[ST_EMPTY]             = fifoEmpty;
      statusWord[ST_FULL]              = fifoFull;
      mmioRead                         = (offset == REG_STATUS) ? statusWord : '0;
   end

   // Register the read source so MMIO loads line up with the 1-cycle RAM read
   always_ff @(posedge clock) begin
      if (!reset) begin
         selQ  <= 1'b0;
         mmioQ <= '0;
      end else begin
         selQ  <= hit;
         mmioQ <= mmioRead;
      end
   end

   assign cpu_rdata = selQ ? mmioQ : ram_rdata;

   // Sticky overflow; a drop on the same edge as a clear keeps it set
   always_ff @(posedge clock) begin
      if (!reset)        overflow <= 1'b0;
      else if (ovfSet)   overflow <= 1'b1;
      else if (ovfClear) overflow <= 1'b0;
   end

   // Frame sequencer; every state lasts CLKS_PER_BIT clocks, data rotates so XOR still gives parity
   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= TX_IDLE;
         uart_tx  <= 1'b1;
         bitCnt   <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
      end else begin
         case (state)
            TX_IDLE: begin
               if (!fifoEmpty) begin
                  shiftReg <= fifoData;
                  bitCnt   <= '0;
                  state    <= TX_START;
                  uart_tx  <= 1'b0;
               end
            end
            TX_START: begin
               if (lastTick) begin
                  bitCnt  <= '0;
                  bitIdx  <= '0;
                  state   <= TX_DATA;
                  uart_tx <= shiftReg[0];
               end else begin
                  bitCnt <= bitCnt + BW'(1);
               end
            end
            TX_DATA: begin
               if (lastTick) begin
                  bitCnt <= '0;
                  if (bitIdx == 3'd7) begin
`ifdef UART_PARITY_EN
                     state   <= TX_PARITY;
                     uart_tx <= ^shiftReg;
`else
                     state   <= TX_STOP;
                     uart_tx <= 1'b1;
`endif
                  end else begin
                     bitIdx   <= bitIdx + 3'd1;
                     shiftReg <= {shiftReg[0], shiftReg[7:1]};
                     uart_tx  <= shiftReg[1];
                  end
               end else begin
                  bitCnt <= bitCnt + BW'(1);
               end
            end
            TX_PARITY: begin
               if (lastTick) begin
                  bitCnt  <= '0;
                  state   <= TX_STOP;
                  uart_tx <= 1'b1;
               end else begin
                  bitCnt <= bitCnt + BW'(1);
               end
            end
            TX_STOP: begin
               if (lastTick) begin
                  bitCnt <= '0;
                  if (!fifoEmpty) begin
                     shiftReg <= fifoData;
                     state    <= TX_START;
                     uart_tx  <= 1'b0;
                  end else begin
                     state <= TX_IDLE;
                  end
               end else begin
                  bitCnt <= bitCnt + BW'(1);
               end
            end
            default: begin
               state   <= TX_IDLE;
               uart_tx <= 1'b1;
            end
         endcase
      end
   end

endmodule
